// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control slice:
// stage indices, default exception vector and FSM state encodings.
package pipe_ctrl_pkg;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_M = 3;
  localparam int unsigned STG_W = 4;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

endpackage

// File: rtl/pipe_ctrl_fetch_track.sv
// Outstanding instruction-fetch counter and squash/drop bookkeeping.
// Responses return in order, so the first drop_cnt responses are stale.
module fetch_track #(
  parameter int MAX_OUTST = 3,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic if_req_fire,
  input  logic if_resp_valid,
  input  logic squash,
  output logic if_resp_drop,
  output logic outst_full,
  output logic drop_nz
);

  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  assign outst_full   = (outst_q == CNT_W'(MAX_OUTST));
  assign drop_nz      = (drop_q != '0);
  assign if_resp_drop = if_resp_valid & drop_nz;

  always_comb begin
    outst_d = outst_q;
    unique case ({if_req_fire, if_resp_valid})
      2'b10:   if (!outst_full) outst_d = outst_q + CNT_W'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Everything in flight, including a request firing now, is squashed.
  always_comb begin
    drop_d = drop_q;
    if (squash)
      drop_d = outst_q - CNT_W'(if_resp_valid) + CNT_W'(if_req_fire);
    else if (if_resp_drop)
      drop_d = drop_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  a_no_fire_full: assert property (@(posedge clk) disable iff (!resetn)
    !(if_req_fire && !if_resp_valid && outst_full));

  a_no_resp_empty: assert property (@(posedge clk) disable iff (!resetn)
    !(if_resp_valid && outst_q == '0));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush generation, exception/ERET redirect FSM,
// and squashing of in-flight instruction fetches.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int              NSTAGE    = 5,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEFAULT),
  parameter int              MAX_OUTST = 3,
  parameter int              CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              except_valid,
  input  logic              except_eret,
  input  logic [PC_W-1:0]   epc,
  input  logic              if_req_fire,
  input  logic              if_resp_valid,
  output logic              if_resp_drop,
  output logic              outst_full,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              redirect_ack,
  output logic              busy
);

  logic [0:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [NSTAGE-1:0] stall_raw;
  logic              in_redir;
  logic              drop_nz;

  assign in_redir = (state_q == REDIRECT);

  // A stalled stage freezes every earlier stage.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_raw = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc          = acc | stall_req[i];
      stall_raw[i] = acc;
    end
  end

  always_comb begin
    stall = stall_raw;
    if (in_redir) stall[STG_F] = 1'b0;
    flush = '0;
    for (int i = 0; i < NSTAGE - 1; i++)
      flush[i+1] = stall[i] & ~stall[i+1];
    if (in_redir) flush[STG_F] = 1'b1;
    if (except_valid) begin
      stall = '0;
      flush = '1;
    end
    if (!resetn) begin
      stall = '0;
      flush = '0;
    end
  end

  // A fresh exception wins over an ack arriving the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (except_valid) begin
      state_d = REDIRECT;
      pc_d    = except_eret ? epc : EXC_VEC;
    end else if (in_redir && redirect_ack) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_track #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_fetch_track (
    .clk           (clk),
    .resetn        (resetn),
    .if_req_fire   (if_req_fire),
    .if_resp_valid (if_resp_valid),
    .squash        (except_valid),
    .if_resp_drop  (if_resp_drop),
    .outst_full    (outst_full),
    .drop_nz       (drop_nz)
  );

  assign redirect_valid = in_redir;
  assign redirect_pc    = pc_q;
  assign busy           = in_redir | drop_nz;

endmodule
